// File: rtl/lsu_riscv.sv
// Load/store unit: one access at a time, stalls the core until a variable-latency memory answers or times out.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses (misalign pulse) instead of silently aligning them.
module lsu_riscv #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [2:0]          core_size,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_stall,
    output logic                bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                misalign,
`endif
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [2:0]       size_q;
    logic [OFF_W-1:0] off_q;
    logic [CNT_W-1:0] cnt;

    logic              size_ok;
    logic [2:0]        align_mask;
    logic [7:0]        mask8;
    logic [ADDR_W-1:0] addr_al;
    logic [OFF_W-1:0]  off;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] rshift;
    logic [DATA_W-1:0] rext;

    always_comb begin
        size_ok    = (core_size[2:1] != 2'b11) && ((core_size != 3'b011) || (DATA_W == 64));
        align_mask = 3'b000;
        mask8      = 8'h01;
        case (core_size[1:0])
            2'b01:   begin align_mask = 3'b001; mask8 = 8'h03; end
            2'b10:   begin align_mask = 3'b011; mask8 = 8'h0F; end
            2'b11:   begin align_mask = 3'b111; mask8 = 8'hFF; end
            default: begin align_mask = 3'b000; mask8 = 8'h01; end
        endcase
        // Below-size address bits are dropped; under the trap macro any such access never reaches the bus.
        addr_al = core_addr & ~ADDR_W'(align_mask);
        off     = addr_al[OFF_W-1:0];
        be      = BE_W'(mask8) << off;
    end

    always_comb begin
        rshift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            3'b000:  rext = DATA_W'($signed(rshift[7:0]));
            3'b001:  rext = DATA_W'($signed(rshift[15:0]));
            3'b010:  rext = DATA_W'($signed(rshift[31:0]));
            3'b100:  rext = DATA_W'(rshift[7:0]);
            3'b101:  rext = DATA_W'(rshift[15:0]);
            default: rext = rshift;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_trap;
    assign mis_trap = (addr_al != core_addr);
`endif

    assign core_stall = ((state == IDLE) && core_req) || (state == REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            size_q     <= 3'b000;
            off_q      <= '0;
            cnt        <= '0;
            core_rdata <= '0;
            bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign <= 1'b0;
`endif
                    if (core_req) begin
                        if (!size_ok) begin
                            bus_err    <= 1'b1;
                            core_rdata <= '0;
                            state      <= DONE;
`ifdef LSU_MISALIGN_TRAP_EN
                        end else if (mis_trap) begin
                            misalign   <= 1'b1;
                            core_rdata <= '0;
                            state      <= DONE;
`endif
                        end else begin
                            size_q    <= core_size;
                            off_q     <= off;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= core_we;
                            mem_be    <= be;
                            mem_addr  <= {addr_al[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= core_wdata << {off, 3'b000};
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) core_rdata <= rext;
                        state <= DONE;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        mem_req    <= 1'b0;
                        bus_err    <= 1'b1;
                        core_rdata <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
